// File: rtl/kitchen_op_sequencer_if.sv
// rtl/kitchen_op_sequencer_if.sv - command, feedback and transmit signal bundle for kitchen_op_sequencer
//
// Groups every non-clock/reset signal of kitchen_op_sequencer.
//   cmd_valid/cmd_ready/cmd_op/cmd_target : one command per handshake
//   status_valid + four feedback bits      : decoded receive-side feedback strobe
//   tx_data/tx_valid/tx_ready              : byte packets towards the UART transmitter
//   busy/done/err_code                     : command progress and result
// Modports: master = command source / feedback decoder / transmitter side,
//           slave  = the sequencer itself.
interface kitchen_op_sequencer_if;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [2:0] cmd_op;
    logic [5:0] cmd_target;

    logic       status_valid;
    logic       traveler_in_front_of_target_machine;
    logic       traveler_has_item_in_hand;
    logic       target_machine_is_processing;
    logic       target_machine_has_item;

    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;

    logic       busy;
    logic       done;
    logic [1:0] err_code;

    modport master (
        output cmd_valid, cmd_op, cmd_target,
        output status_valid, traveler_in_front_of_target_machine, traveler_has_item_in_hand,
        output target_machine_is_processing, target_machine_has_item,
        output tx_ready,
        input  cmd_ready, tx_data, tx_valid, busy, done, err_code
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_target,
        input  status_valid, traveler_in_front_of_target_machine, traveler_has_item_in_hand,
        input  target_machine_is_processing, target_machine_has_item,
        input  tx_ready,
        output cmd_ready, tx_data, tx_valid, busy, done, err_code
    );
endinterface

// File: rtl/kitchen_op_sequencer.sv
// rtl/kitchen_op_sequencer.sv - sequences one kitchen command into select/move/operate packets
//
// Ports:
//   clk  : system clock
//   rst  : synchronous active-high reset
//   bus  : kitchen_op_sequencer_if.slave
//          cmd_*     command in (cmd_ready high only while idle)
//          status_*  decoded feedback, bits sampled only when status_valid is high
//          tx_*      packet out, tx_data held stable until tx_ready
//          busy/done/err_code  progress and per-command result
//            err_code: 0 ok, 1 timeout, 2 illegal op, 3 precondition fail
// Parameter:
//   TIMEOUT_CYCLES : cycles allowed in any wait state before abort
// Optional build macro:
//   KITCHEN_SEQ_TIMEOUT_EN : enables the per-wait timeout counter; without it
//                            waits are unbounded and err_code 1 is never produced.
module kitchen_op_sequencer #(
    parameter int unsigned TIMEOUT_CYCLES = 100_000_000
) (
    input  logic                  clk,
    input  logic                  rst,
    kitchen_op_sequencer_if.slave bus
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SEND_SEL,
        ST_WAIT_SEL,
        ST_SEND_MOVE,
        ST_WAIT_ARRIVE,
        ST_SEND_ACT,
        ST_WAIT_RESULT,
        ST_FINISH
    } state_t;

    localparam logic [2:0] OP_GET      = 3'd0;
    localparam logic [2:0] OP_PUT      = 3'd1;
    localparam logic [2:0] OP_INTERACT = 3'd2;
    localparam logic [2:0] OP_THROW    = 3'd3;
    localparam logic [2:0] OP_WAIT     = 3'd4;

    localparam logic [1:0] ERR_OK      = 2'd0;
    localparam logic [1:0] ERR_TIMEOUT = 2'd1;
    localparam logic [1:0] ERR_ILLEGAL = 2'd2;
    localparam logic [1:0] ERR_PRECOND = 2'd3;

    // One-hot action field of the operate packet.
    localparam logic [4:0] ACT_GET      = 5'b00001;
    localparam logic [4:0] ACT_PUT      = 5'b00010;
    localparam logic [4:0] ACT_INTERACT = 5'b00100;
    localparam logic [4:0] ACT_MOVE     = 5'b01000;
    localparam logic [4:0] ACT_THROW    = 5'b10000;

    state_t     state;
    state_t     state_next;
    logic [2:0] op_q;
    logic [5:0] target_q;
    logic [1:0] err_q;
    logic [1:0] err_next;

    logic       fb_front;
    logic       fb_hand;
    logic       fb_processing;
    logic       fb_item;

    logic [4:0] act;
    logic [7:0] sel_pkt;
    logic [7:0] move_pkt;
    logic [7:0] act_pkt;
    logic       precond_fail;
    logic       result_met;
    logic       in_wait;
    logic       timeout_hit;

    logic       tx_valid_c;
    logic [7:0] tx_data_c;

    assign fb_front      = bus.traveler_in_front_of_target_machine;
    assign fb_hand       = bus.traveler_has_item_in_hand;
    assign fb_processing = bus.target_machine_is_processing;
    assign fb_item       = bus.target_machine_has_item;

    // Action bits for the latched op; WAIT and illegal ops never reach SEND_ACT.
    always_comb begin
        act = 5'b00000;
        case (op_q)
            OP_GET:      act = ACT_GET;
            OP_PUT:      act = ACT_PUT;
            OP_INTERACT: act = ACT_INTERACT;
            OP_THROW:    act = ACT_THROW;
            default:     act = 5'b00000;
        endcase
    end

    assign sel_pkt  = {target_q, 2'b11};
    assign move_pkt = {1'b0, ACT_MOVE, 2'b10};
    assign act_pkt  = {1'b0, act, 2'b10};

    // Hand state must suit the op before anything moves: GET needs an empty
    // hand, PUT/THROW need something in hand.
    always_comb begin
        precond_fail = 1'b0;
        case (op_q)
            OP_GET:           precond_fail = fb_hand;
            OP_PUT, OP_THROW: precond_fail = !fb_hand;
            default:          precond_fail = 1'b0;
        endcase
    end

    // Completion condition, evaluated on a strobe in WAIT_RESULT.
    always_comb begin
        result_met = 1'b0;
        case (op_q)
            OP_GET:           result_met = fb_hand;
            OP_PUT, OP_THROW: result_met = !fb_hand;
            OP_INTERACT:      result_met = 1'b1;
            OP_WAIT:          result_met = !fb_processing && fb_item;
            default:          result_met = 1'b0;
        endcase
    end

    assign in_wait = (state == ST_WAIT_SEL) || (state == ST_WAIT_ARRIVE) ||
                     (state == ST_WAIT_RESULT);

`ifdef KITCHEN_SEQ_TIMEOUT_EN
    localparam logic [31:0] WAIT_LIMIT = 32'(TIMEOUT_CYCLES - 1);

    logic [31:0] wait_cnt;

    // Any state change clears the count, so every wait starts from zero; the
    // count of the current cycle equals the number of cycles already spent.
    always_ff @(posedge clk) begin
        if (rst) begin
            wait_cnt <= 32'd0;
        end else if (state_next != state) begin
            wait_cnt <= 32'd0;
        end else if (in_wait) begin
            wait_cnt <= wait_cnt + 32'd1;
        end
    end

    assign timeout_hit = in_wait && (wait_cnt == WAIT_LIMIT);
`else
    logic [31:0] unused_timeout_cycles;

    assign unused_timeout_cycles = 32'(TIMEOUT_CYCLES);
    assign timeout_hit           = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            op_q     <= 3'd0;
            target_q <= 6'd0;
            err_q    <= ERR_OK;
        end else begin
            state <= state_next;
            err_q <= err_next;
            if (state == ST_IDLE && bus.cmd_valid) begin
                op_q     <= bus.cmd_op;
                target_q <= bus.cmd_target;
            end
        end
    end

    // In every wait state a real exit (strobe) is checked before the timeout,
    // so a completing strobe on the last allowed cycle still succeeds.
    always_comb begin
        state_next = state;
        err_next   = err_q;
        tx_valid_c = 1'b0;
        tx_data_c  = 8'd0;

        case (state)
            ST_IDLE: begin
                if (bus.cmd_valid) begin
                    if (bus.cmd_op > OP_WAIT) begin
                        state_next = ST_FINISH;
                        err_next   = ERR_ILLEGAL;
                    end else begin
                        state_next = ST_SEND_SEL;
                    end
                end
            end

            ST_SEND_SEL: begin
                tx_valid_c = 1'b1;
                tx_data_c  = sel_pkt;
                if (bus.tx_ready) begin
                    state_next = ST_WAIT_SEL;
                end
            end

            ST_WAIT_SEL: begin
                if (bus.status_valid) begin
                    if (precond_fail) begin
                        state_next = ST_FINISH;
                        err_next   = ERR_PRECOND;
                    end else if (op_q == OP_WAIT) begin
                        state_next = ST_WAIT_RESULT;
                    end else if (fb_front) begin
                        state_next = ST_SEND_ACT;
                    end else begin
                        state_next = ST_SEND_MOVE;
                    end
                end else if (timeout_hit) begin
                    state_next = ST_FINISH;
                    err_next   = ERR_TIMEOUT;
                end
            end

            ST_SEND_MOVE: begin
                tx_valid_c = 1'b1;
                tx_data_c  = move_pkt;
                if (bus.tx_ready) begin
                    state_next = ST_WAIT_ARRIVE;
                end
            end

            ST_WAIT_ARRIVE: begin
                if (bus.status_valid && fb_front) begin
                    state_next = ST_SEND_ACT;
                end else if (timeout_hit) begin
                    state_next = ST_FINISH;
                    err_next   = ERR_TIMEOUT;
                end
            end

            ST_SEND_ACT: begin
                tx_valid_c = 1'b1;
                tx_data_c  = act_pkt;
                if (bus.tx_ready) begin
                    state_next = ST_WAIT_RESULT;
                end
            end

            ST_WAIT_RESULT: begin
                if (bus.status_valid && result_met) begin
                    state_next = ST_FINISH;
                    err_next   = ERR_OK;
                end else if (timeout_hit) begin
                    state_next = ST_FINISH;
                    err_next   = ERR_TIMEOUT;
                end
            end

            ST_FINISH: begin
                state_next = ST_IDLE;
            end

            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    assign bus.cmd_ready = (state == ST_IDLE);
    assign bus.busy      = (state != ST_IDLE);
    assign bus.done      = (state == ST_FINISH);
    assign bus.err_code  = err_q;
    assign bus.tx_valid  = tx_valid_c;
    assign bus.tx_data   = tx_data_c;

endmodule

// File: tb/tb_kitchen_op_sequencer.sv
// tb/tb_kitchen_op_sequencer.sv - self-checking bench for kitchen_op_sequencer
module tb_kitchen_op_sequencer;

    localparam int unsigned TO_CYCLES = 16;

    localparam logic [2:0] OP_GET      = 3'd0;
    localparam logic [2:0] OP_PUT      = 3'd1;
    localparam logic [2:0] OP_INTERACT = 3'd2;
    localparam logic [2:0] OP_THROW    = 3'd3;
    localparam logic [2:0] OP_WAIT     = 3'd4;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    kitchen_op_sequencer_if bus ();

    kitchen_op_sequencer #(.TIMEOUT_CYCLES(TO_CYCLES)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Feedback vectors are {in_front, hand, processing, has_item}; script
    // entries add a top "skip" bit meaning "no strobe in this wait cycle".
    logic [7:0] got_bytes[$];
    logic [3:0] sent[$];
    logic [4:0] script[$];
    bit         script_only = 1'b0;
    int         hold_ready  = 0;

    logic [1:0] got_err;
    int         done_cyc;
    int         last_strobe_cyc;
    int         first_hs_cyc;
    int         stab_err;
    bit         done_long;
    bit         tx_at_1;
    bit         saw_tx;

    logic [7:0] exp_bytes[$];
    logic [1:0] exp_err;
    bit         exp_fin;
    int         exp_used;

    task automatic drive_fb(input logic [3:0] fb);
        {bus.traveler_in_front_of_target_machine, bus.traveler_has_item_in_hand,
         bus.target_machine_is_processing, bus.target_machine_has_item} = fb;
    endtask

    // Reference: packets are plain arithmetic on the protocol fields.
    function automatic logic [7:0] op_byte(input int bitpos);
        return 8'((1 << bitpos) * 4 + 2);
    endfunction

    function automatic int op_bitpos(input logic [2:0] op);
        return (op == OP_THROW) ? 4 : int'(op);
    endfunction

    // Walks the strobes actually delivered in wait states through the command
    // rules: what the command is waiting for, which bytes it emits, how it ends.
    task automatic model_cmd(input logic [2:0] op, input logic [5:0] tgt);
        int  need;   // 0 first feedback, 1 arrival, 2 result
        bit  front, hand, proc, item;
        exp_bytes.delete();
        exp_fin  = 1'b0;
        exp_used = 0;
        exp_err  = 2'd0;
        if (op > 3'd4) begin
            exp_err = 2'd2;
            exp_fin = 1'b1;
            return;
        end
        exp_bytes.push_back(8'(tgt * 4 + 3));
        need = 0;
        foreach (sent[i]) begin
            if (exp_fin) break;
            {front, hand, proc, item} = sent[i];
            exp_used = i + 1;
            if (need == 0) begin
                if ((op == OP_GET && hand) || ((op == OP_PUT || op == OP_THROW) && !hand)) begin
                    exp_err = 2'd3;
                    exp_fin = 1'b1;
                end else if (op == OP_WAIT) begin
                    need = 2;
                end else if (front) begin
                    exp_bytes.push_back(op_byte(op_bitpos(op)));
                    need = 2;
                end else begin
                    exp_bytes.push_back(op_byte(3));
                    need = 1;
                end
            end else if (need == 1) begin
                if (front) begin
                    exp_bytes.push_back(op_byte(op_bitpos(op)));
                    need = 2;
                end
            end else begin
                case (op)
                    OP_GET:           exp_fin = hand;
                    OP_PUT, OP_THROW: exp_fin = !hand;
                    OP_INTERACT:      exp_fin = 1'b1;
                    default:          exp_fin = !proc && item;
                endcase
            end
        end
    endtask

    // Issues one command and services the sequencer until done or budget.
    task automatic run_cmd(input logic [2:0] op, input logic [5:0] tgt,
                           input int ready_pct, input int strobe_pct);
        logic       prev_hold;
        logic [7:0] prev_data;
        logic [4:0] ent;
        logic [3:0] fb;
        int         held;
        got_bytes.delete();
        sent.delete();
        got_err = 2'd0; done_cyc = -1; last_strobe_cyc = -1; first_hs_cyc = -1;
        stab_err = 0; done_long = 1'b0; tx_at_1 = 1'b0; saw_tx = 1'b0;
        prev_hold = 1'b0; prev_data = 8'd0; held = 0;
        @(negedge clk);
        bus.cmd_valid = 1'b1; bus.cmd_op = op; bus.cmd_target = tgt;
        for (int cyc = 1; cyc <= 400; cyc++) begin
            @(negedge clk);
            bus.cmd_valid = 1'b0;
            bus.cmd_op = 3'($urandom);
            bus.cmd_target = 6'($urandom);
            if (prev_hold && (bus.tx_valid !== 1'b1 || bus.tx_data !== prev_data)) stab_err++;
            if (cyc == 1 && bus.tx_valid === 1'b1) tx_at_1 = 1'b1;
            if (bus.tx_valid === 1'b1) saw_tx = 1'b1;
            if (bus.done === 1'b1) begin
                got_err = bus.err_code;
                done_cyc = cyc;
                break;
            end
            bus.status_valid = 1'b0;
            bus.tx_ready = 1'b0;
            if (bus.tx_valid === 1'b1) begin
                if (held < hold_ready) held++;
                else bus.tx_ready = ($urandom_range(99) < ready_pct);
                if (!bus.tx_ready || $urandom_range(2) == 0) begin
                    bus.status_valid = 1'b1;
                    drive_fb((held > 0 && held <= hold_ready && !bus.tx_ready) ? 4'b0100 : 4'($urandom));
                end
            end else if (bus.busy === 1'b1) begin
                if (script.size() > 0) begin
                    ent = script.pop_front();
                    if (!ent[4]) begin
                        bus.status_valid = 1'b1;
                        drive_fb(ent[3:0]);
                        sent.push_back(ent[3:0]);
                        last_strobe_cyc = cyc;
                    end
                end else if (!script_only && $urandom_range(99) < strobe_pct) begin
                    fb = (sent.size() < 8) ? 4'($urandom) : {1'b1, op == OP_GET, 1'b0, 1'b1};
                    bus.status_valid = 1'b1;
                    drive_fb(fb);
                    sent.push_back(fb);
                    last_strobe_cyc = cyc;
                end
            end
            if (bus.tx_valid === 1'b1 && bus.tx_ready === 1'b1) begin
                got_bytes.push_back(bus.tx_data);
                if (first_hs_cyc < 0) first_hs_cyc = cyc;
            end
            prev_hold = bus.tx_valid && !bus.tx_ready;
            prev_data = bus.tx_data;
        end
        bus.status_valid = 1'b0;
        bus.tx_ready = 1'b0;
        script.delete();
        if (done_cyc >= 0) begin
            @(negedge clk);
            if (bus.done !== 1'b0 || bus.cmd_ready !== 1'b1) done_long = 1'b1;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        n_checks++; if (bus.cmd_ready !== 1'b1) begin n_fail++; $display("FAIL reset_cmd_ready got %b want 1", bus.cmd_ready); end
        n_checks++; if (bus.tx_valid !== 1'b0) begin n_fail++; $display("FAIL reset_tx_valid got %b want 0", bus.tx_valid); end
        n_checks++; if (bus.tx_data !== 8'h00) begin n_fail++; $display("FAIL reset_tx_data got %h want 00", bus.tx_data); end
        n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", bus.busy); end
        n_checks++; if (bus.done !== 1'b0) begin n_fail++; $display("FAIL reset_done got %b want 0", bus.done); end
        n_checks++; if (bus.err_code !== 2'd0) begin n_fail++; $display("FAIL reset_err got %0d want 0", bus.err_code); end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_get_direct();
        script_only = 1'b1;
        script = '{5'b01000, 5'b00100};
        run_cmd(OP_GET, 6'd5, 100, 0);
        n_checks++; if (got_bytes.size() != 2 || got_bytes[0] !== 8'h17 || got_bytes[1] !== 8'h06) begin
            n_fail++; $display("FAIL get_bytes got %0d bytes first %h want 17 06", got_bytes.size(), got_bytes.size() > 0 ? got_bytes[0] : 8'h0); end
        n_checks++; if (done_cyc < 0 || got_err !== 2'd0) begin n_fail++; $display("FAIL get_err got %0d done_cyc %0d want 0", got_err, done_cyc); end
        n_checks++; if (!tx_at_1) begin n_fail++; $display("FAIL get_first_tx got 0 want tx_valid at T+1"); end
        n_checks++; if (done_cyc != last_strobe_cyc + 1) begin n_fail++; $display("FAIL get_done_timing got %0d want %0d", done_cyc, last_strobe_cyc + 1); end
    endtask

    task automatic test_put_move();
        script_only = 1'b1;
        script = '{5'b00100, 5'b00000, 5'b00100, 5'b01000, 5'b00000};
        run_cmd(OP_PUT, 6'd2, 70, 0);
        n_checks++; if (got_bytes.size() != 3 || got_bytes[0] !== 8'h0B || got_bytes[1] !== 8'h22 || got_bytes[2] !== 8'h0A) begin
            n_fail++; $display("FAIL put_bytes got %0d bytes want 0B 22 0A", got_bytes.size()); end
        n_checks++; if (done_cyc < 0 || got_err !== 2'd0) begin n_fail++; $display("FAIL put_err got %0d done_cyc %0d want 0", got_err, done_cyc); end
        n_checks++; if (sent.size() != 5 || done_cyc != last_strobe_cyc + 1) begin
            n_fail++; $display("FAIL put_strobes got %0d strobes done %0d want 5 strobes done %0d", sent.size(), done_cyc, last_strobe_cyc + 1); end
    endtask

    task automatic test_backpressure();
        script_only = 1'b1;
        hold_ready = 10;
        script = '{5'b01000, 5'b00100};
        run_cmd(OP_GET, 6'd3, 100, 0);
        hold_ready = 0;
        n_checks++; if (first_hs_cyc != 11) begin n_fail++; $display("FAIL bp_first_handshake got cycle %0d want 11", first_hs_cyc); end
        n_checks++; if (stab_err != 0) begin n_fail++; $display("FAIL bp_stable got %0d unstable cycles want 0", stab_err); end
        n_checks++; if (got_bytes.size() != 2 || got_bytes[0] !== 8'h0F || got_bytes[1] !== 8'h06) begin
            n_fail++; $display("FAIL bp_bytes got %0d bytes want 0F 06", got_bytes.size()); end
        n_checks++; if (got_err !== 2'd0 || done_cyc < 0) begin n_fail++; $display("FAIL bp_err got %0d want 0", got_err); end
    endtask

    task automatic test_illegal();
        for (int op = 5; op <= 7; op++) begin
            script_only = 1'b1;
            run_cmd(3'(op), 6'($urandom), 100, 0);
            n_checks++; if (done_cyc != 1 || got_err !== 2'd2) begin
                n_fail++; $display("FAIL illegal_%0d got done_cyc %0d err %0d want 1 and 2", op, done_cyc, got_err); end
            n_checks++; if (saw_tx || got_bytes.size() != 0) begin n_fail++; $display("FAIL illegal_tx_%0d got tx activity want none", op); end
            n_checks++; if (done_long) begin n_fail++; $display("FAIL illegal_pulse_%0d got done longer than 1 cycle", op); end
        end
    endtask

    task automatic test_precond();
        script_only = 1'b1;
        script = '{5'b01100};
        run_cmd(OP_GET, 6'd1, 100, 0);
        n_checks++; if (got_err !== 2'd3 || got_bytes.size() != 1 || got_bytes[0] !== 8'h07) begin
            n_fail++; $display("FAIL precond_get got err %0d bytes %0d want 3 and 1", got_err, got_bytes.size()); end
        repeat (4) @(negedge clk);
        n_checks++; if (bus.err_code !== 2'd3 || bus.done !== 1'b0) begin
            n_fail++; $display("FAIL err_hold got err %0d done %b want 3 0", bus.err_code, bus.done); end
        script = '{5'b01000};
        run_cmd(OP_THROW, 6'd40, 100, 0);
        n_checks++; if (got_err !== 2'd3 || got_bytes.size() != 1) begin
            n_fail++; $display("FAIL precond_throw got err %0d bytes %0d want 3 and 1", got_err, got_bytes.size()); end
    endtask

`ifdef KITCHEN_SEQ_TIMEOUT_EN
    task automatic test_timeout();
        script_only = 1'b1;
        script = '{5'b00010};
        run_cmd(OP_WAIT, 6'd4, 100, 0);
        n_checks++; if (got_err !== 2'd1 || done_cyc != last_strobe_cyc + 17) begin
            n_fail++; $display("FAIL timeout got err %0d done_cyc %0d want 1 and %0d", got_err, done_cyc, last_strobe_cyc + 17); end
        script.delete();
        script.push_back(5'b00010);
        repeat (15) script.push_back(5'b00010);
        script.push_back(5'b00001);
        run_cmd(OP_WAIT, 6'd4, 100, 0);
        n_checks++; if (got_err !== 2'd0 || sent.size() != 17 || done_cyc != last_strobe_cyc + 1) begin
            n_fail++; $display("FAIL timeout_edge got err %0d strobes %0d want 0 and 17", got_err, sent.size()); end
    endtask
`else
    task automatic test_timeout();
        script_only = 1'b1;
        script.delete();
        script.push_back(5'b00010);
        repeat (40) script.push_back(5'b10000);
        script.push_back(5'b00001);
        run_cmd(OP_WAIT, 6'd4, 100, 0);
        n_checks++; if (got_err !== 2'd0 || done_cyc != last_strobe_cyc + 1) begin
            n_fail++; $display("FAIL unbounded_wait got err %0d done_cyc %0d want 0 and %0d", got_err, done_cyc, last_strobe_cyc + 1); end
    endtask
`endif

    task automatic test_reset_mid();
        bit saw_done = 1'b0;
        @(negedge clk);
        bus.cmd_valid = 1'b1; bus.cmd_op = OP_PUT; bus.cmd_target = 6'd9;
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        n_checks++; if (bus.tx_valid !== 1'b1 || bus.tx_data !== 8'h27) begin
            n_fail++; $display("FAIL rm_select got valid %b data %h want 1 27", bus.tx_valid, bus.tx_data); end
        bus.tx_ready = 1'b1;
        @(negedge clk);
        bus.tx_ready = 1'b0;
        n_checks++; if (bus.tx_valid !== 1'b0) begin n_fail++; $display("FAIL rm_after_hs got tx_valid %b want 0", bus.tx_valid); end
        bus.status_valid = 1'b1; drive_fb(4'b0100);
        @(negedge clk);
        bus.status_valid = 1'b0;
        n_checks++; if (bus.tx_valid !== 1'b1 || bus.tx_data !== 8'h22) begin
            n_fail++; $display("FAIL rm_move got valid %b data %h want 1 22", bus.tx_valid, bus.tx_data); end
        bus.tx_ready = 1'b1;
        @(negedge clk);
        bus.tx_ready = 1'b0;
        if (bus.done === 1'b1) saw_done = 1'b1;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        n_checks++; if (bus.cmd_ready !== 1'b1 || bus.busy !== 1'b0 || bus.tx_valid !== 1'b0 || bus.done !== 1'b0) begin
            n_fail++; $display("FAIL rm_state got ready %b busy %b txv %b done %b want 1 0 0 0", bus.cmd_ready, bus.busy, bus.tx_valid, bus.done); end
        repeat (3) begin @(negedge clk); if (bus.done === 1'b1) saw_done = 1'b1; end
        n_checks++; if (saw_done) begin n_fail++; $display("FAIL rm_no_done got done pulse want none"); end
        script_only = 1'b1;
        script = '{5'b01000, 5'b00000};
        run_cmd(OP_INTERACT, 6'd7, 100, 0);
        n_checks++; if (got_err !== 2'd0 || got_bytes.size() != 2 || got_bytes[0] !== 8'h1F || got_bytes[1] !== 8'h12) begin
            n_fail++; $display("FAIL rm_next_cmd got err %0d bytes %0d want 0 and 1F 12", got_err, got_bytes.size()); end
    endtask

    task automatic test_random();
        logic [2:0] op;
        logic [5:0] tgt;
        bit         bad;
        int         spct;
`ifdef KITCHEN_SEQ_TIMEOUT_EN
        spct = 100;
`else
        spct = 50;
`endif
        script_only = 1'b0;
        for (int n = 0; n < 40; n++) begin
            op  = 3'($urandom_range(7));
            tgt = 6'($urandom);
            run_cmd(op, tgt, 1 + $urandom_range(99), spct);
            model_cmd(op, tgt);
            bad = (got_bytes.size() != exp_bytes.size());
            if (!bad) foreach (exp_bytes[i]) if (got_bytes[i] !== exp_bytes[i]) bad = 1'b1;
            n_checks++; if (done_cyc < 0) begin n_fail++; $display("FAIL rnd_done cmd %0d op %0d got no done want done", n, op); end
            n_checks++; if (got_err !== exp_err) begin n_fail++; $display("FAIL rnd_err cmd %0d op %0d got %0d want %0d", n, op, got_err, exp_err); end
            n_checks++; if (bad) begin n_fail++; $display("FAIL rnd_bytes cmd %0d op %0d got %0d bytes want %0d", n, op, got_bytes.size(), exp_bytes.size()); end
            n_checks++; if (!exp_fin || exp_used != sent.size()) begin
                n_fail++; $display("FAIL rnd_strobes cmd %0d op %0d got %0d strobes consumed want model end at %0d", n, op, sent.size(), exp_used); end
            n_checks++; if (stab_err != 0 || done_long) begin n_fail++; $display("FAIL rnd_protocol cmd %0d got unstable %0d long_done %b want 0 0", n, stab_err, done_long); end
            if (op > 3'd4) begin
                n_checks++; if (done_cyc != 1 || saw_tx) begin n_fail++; $display("FAIL rnd_illegal cmd %0d got done_cyc %0d tx %b want 1 0", n, done_cyc, saw_tx); end
            end else begin
                n_checks++; if (!tx_at_1 || done_cyc != last_strobe_cyc + 1) begin
                    n_fail++; $display("FAIL rnd_timing cmd %0d got tx1 %b done %0d want 1 %0d", n, tx_at_1, done_cyc, last_strobe_cyc + 1); end
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        bus.cmd_valid = 1'b0; bus.cmd_op = 3'd0; bus.cmd_target = 6'd0;
        bus.status_valid = 1'b0; drive_fb(4'b0000);
        bus.tx_ready = 1'b0;
        test_reset();
        test_get_direct();
        test_put_move();
        test_backpressure();
        test_illegal();
        test_precond();
        test_timeout();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog got no end of test want finish before limit");
        $fatal(1);
    end

endmodule
